// File: rtl/seg4_scan_driver.sv
// seg4_scan_driver: time-multiplexed driver for a 4-digit common-anode 7-segment module.
// Takes packed BCD plus decimal points over a valid/ready load handshake. New values
// reach the display only at frame boundaries, so a frame never mixes two values.
// Optional build macro: SEG4_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg4_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYC);

  // Active-low glyph for one nibble; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1011000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b0111111;
    endcase
    return g;
  endfunction

  // Scan state
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            slot_end;

  // Load / display state
  logic [15:0] pend_q, pend_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic        accept, commit;

  // Output next-state
  logic        blank_win, seg_load;
  logic [3:0]  an_d;
  logic        frame_tick_d;
  logic [3:0]  nib_sel;
  logic        dp_sel;
  logic [6:0]  glyph;
  logic [6:0]  seg_d;
  logic        dp_n_d;

  // Slot counter wraps at SCAN_DIV-1 and steps the digit index.
  always_comb begin
    slot_end = (cnt_q == CntMax);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
  end

  // Handshake and frame-synchronous commit; accept needs an empty pending slot,
  // so accept and commit can never hit the same cycle.
  always_comb begin
    accept     = in_valid && in_ready;
    commit     = frame_tick && pend_vld_q;
    pend_d     = accept ? bcd_in : pend_q;
    pend_dp_d  = accept ? dp_in : pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (accept) begin
      pend_vld_d = 1'b1;
    end else if (commit) begin
      pend_vld_d = 1'b0;
    end
    disp_d    = commit ? pend_q : disp_q;
    disp_dp_d = commit ? pend_dp_q : disp_dp_q;
  end

`ifdef SEG4_LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;

  // A digit is a leading zero when it and every higher digit is 0 with no dp lit.
  always_comb begin
    lead_zero[3] = (disp_d[15:12] == 4'd0) && !disp_dp_d[3];
    lead_zero[2] = lead_zero[3] && (disp_d[11:8] == 4'd0) && !disp_dp_d[2];
    lead_zero[1] = lead_zero[2] && (disp_d[7:4] == 4'd0) && !disp_dp_d[1];
    lead_zero[0] = 1'b0;
  end
`endif

  // Output next-state, computed from next-state scan position so registered
  // outputs line up with the counter they describe.
  always_comb begin
    blank_win    = (cnt_d < BlankCnt);
    // Slot start reload also covers BLANK_CYC of 0.
    seg_load     = blank_win || (cnt_d == '0);
    an_d         = blank_win ? 4'hF : ~(4'b0001 << idx_d);
    frame_tick_d = (cnt_d == CntMax) && (idx_d == 2'd3);

    unique case (idx_d)
      2'd0: nib_sel = disp_d[3:0];
      2'd1: nib_sel = disp_d[7:4];
      2'd2: nib_sel = disp_d[11:8];
      2'd3: nib_sel = disp_d[15:12];
    endcase
    dp_sel = disp_dp_d[idx_d];

    glyph = decode(nib_sel);
`ifdef SEG4_LEADING_ZERO_BLANK_EN
    if (lead_zero[idx_d]) begin
      glyph = 7'h7F;
    end
`endif

    seg_d  = seg_load ? glyph : seg_n;
    dp_n_d = seg_load ? !dp_sel : dp_n;
  end

  // Scan counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Pending and display registers plus in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_vld_q <= 1'b0;
      disp_q     <= 16'h0000;
      disp_dp_q  <= 4'h0;
      in_ready   <= 1'b1;
    end else begin
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      in_ready   <= !pend_vld_d;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= seg_d;
      dp_n       <= dp_n_d;
      an_n       <= an_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: doc/seg4_scan_driver.md
Name: seg4_scan_driver

Overview:
- Downstream display stage for BCD-producing counters (stopwatch/clock blocks).
- Accepts a 4-digit packed BCD value plus decimal points over a valid/ready load handshake.
- Drives a time-multiplexed 4-digit common-anode 7-segment module: active-low segments, active-low digit enables.
- Updates are frame-synchronous, so no digit shows a torn value.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
- BLANK_CYC, 1000: cycles at the start of each slot with all anodes off (anti-ghosting); must be < SCAN_DIV.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- bcd_in  in  16  packed BCD; [3:0]=digit0 (rightmost) … [15:12]=digit3
- dp_in  in  4  decimal point request per digit, 1=lit; bit i ↔ digit i
- in_valid  in  1  load request
- in_ready  out  1  block can accept a load
- seg_n  out  7  segments a..g, bit0=a … bit6=g, active-low
- dp_n  out  1  decimal point, active-low
- an_n  out  4  digit enables, one-hot active-low, bit i ↔ digit i
- frame_tick  out  1  one-cycle pulse when digit 3's slot ends

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: seg_n=7'h7F, dp_n=1, an_n=4'hF, frame_tick=0, in_ready=1.
  - Internal state: display register=0x0000/dp=0; pending empty; slot counter=0; digit index=0.
- Slot counter: counts 0..SCAN_DIV-1, then wraps.
  - At wrap, digit index advances 0→1→2→3→0.
  - Wrap from index 3 to 0 pulses frame_tick for exactly that cycle.
- Anodes:
  - Count < BLANK_CYC: an_n=4'hF.
  - Otherwise: an_n = ~(4'b0001 << index).
- Segments:
  - seg_n/dp_n are registered from the display register nibble at the current index.
  - They change only while anodes are blanked.
- Decode, active-low with bit6=g:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000.
  - Nibbles A–F show a dash: 0111111.
- Handshake:
  - A load is accepted on a cycle where in_valid && in_ready.
  - bcd_in/dp_in are captured into the pending register; in_ready drops to 0 on the next cycle.
- Commit:
  - On the cycle frame_tick=1, a non-empty pending register copies into the display register, pending clears, and in_ready returns to 1 on the following cycle.
  - A new value is therefore first visible in digit 0's slot after the next frame boundary.
  - Worst-case latency is 4·SCAN_DIV+2 cycles.
- Accept and frame_tick in the same cycle: the accepted data waits for the following frame, with no bypass. Deterministic tearing-free rule.
- in_valid while in_ready=0: ignored. The upstream stage must hold its data.
- Output stability: outputs are glitch-free registered signals. No combinational path from inputs to outputs.
- Reset mid-frame: everything returns to reset values immediately, and any pending load is discarded.

Optional Feature:
- Macro: SEG4_LEADING_ZERO_BLANK_EN.
- Defined: digits 3, 2 and 1 are blanked (seg_n=7'h7F) when they and all higher digits are 0 and their dp bit is 0. Digit 0 is never blanked. Anode timing is unchanged.
- Undefined: all four digits are always decoded. The blanking logic is absent from the netlist.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
- Reset release, no load: an_n cycles E,D,B,7 (each low 6 of 8 cycles, F for 2); seg_n=1000000 on every digit; frame_tick every 32 cycles.
- Load 0x1234, dp_in=4'b0100: after the next frame_tick, digit0=0011001, digit1=0110000, digit2=0100100 with dp_n=0, digit3=1111001; in_ready low from acceptance until 1 cycle after the commit.
- in_valid held with 0x5678 while in_ready=0, then 0x9999: only values accepted when in_ready=1 appear; no 0x5678 frame if it was never accepted.
- Load 0x00AF: digits 0 and 1 show 0111111 (dash); digits 2 and 3 show 0 (macro off), or are blank (macro on: digit3=digit2=7'h7F).
- Load accepted on the same cycle as frame_tick: the display keeps its old value for one full frame (32 cycles), then shows the new value.
- Assert rst_n=0 mid-slot with a load pending: outputs immediately go to 7'h7F/F/1; after release the display shows 0000 and the pending value is never displayed.
